// File: rtl/display_pkg.sv
// Shared constants and encodings for the tile-map display path.
package display_pkg;
    localparam int TILE_LOG2 = 5;
    localparam int MAP_W     = 20;
    localparam int MAP_H     = 15;

    typedef enum logic [3:0] {
        NONE   = 4'd0,
        WALL   = 4'd1,
        TANK   = 4'd2,
        BULLET = 4'd3
    } category_e;

    typedef enum logic [2:0] {
        LEFT  = 3'b000,
        RIGHT = 3'b001,
        UP    = 3'b010,
        DOWN  = 3'b011
    } direct_e;

    // Map entry layout: {player_tank, tank_direct[2:0], category[3:0]}
    localparam int CAT_LSB    = 0;
    localparam int CAT_W      = 4;
    localparam int DIR_LSB    = 4;
    localparam int DIR_W      = 3;
    localparam int PLAYER_BIT = 7;

    typedef enum logic [1:0] {
        RENDER = 2'd0,
        BLANK  = 2'd1,
        WRITE  = 2'd2
    } arb_state_e;
endpackage

// File: rtl/tile_index_calc.sv
// Pixel coordinate -> map index and in-tile sprite address (combinational).
module tile_index_calc #(
    parameter int TILE_LOG2 = display_pkg::TILE_LOG2
) (
    input  logic [9:0]             pixel_x_i,
    input  logic [9:0]             pixel_y_i,
    output logic [8:0]             index_o,
    output logic [2*TILE_LOG2-1:0] sprite_addr_o
);
    logic [9:0] tx;
    logic [9:0] ty;
    logic [9:0] sum;

    assign tx  = pixel_x_i >> TILE_LOG2;
    assign ty  = pixel_y_i >> TILE_LOG2;
    // ty*20 as (ty*16 + ty*4); wraps to 9 bits for off-screen coordinates
    assign sum = (ty << 4) + (ty << 2) + tx;

    assign index_o       = sum[8:0];
    assign sprite_addr_o = {pixel_y_i[TILE_LOG2-1:0], pixel_x_i[TILE_LOG2-1:0]};
endmodule

// File: rtl/map_render_arbiter.sv
// Tile lookup pipeline for the pixel stage, sharing the map RAM with
// game-logic writes that are only granted during blanking.
module map_render_arbiter #(
    parameter int TILE_LOG2 = 5,
    parameter int MAP_W     = 20,
    parameter int MAP_H     = 15,
    parameter int H_ACTIVE  = 640,
    parameter int V_ACTIVE  = 480
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       video_on,
    input  logic [9:0] pixel_x,
    input  logic [9:0] pixel_y,
    input  logic       wr_req,
    input  logic [8:0] wr_addr,
    input  logic [7:0] wr_data,
    output logic       wr_ack,
    output logic       wr_err,
    output logic [8:0] mem_addr,
    output logic       mem_we,
    output logic [7:0] mem_wdata,
    input  logic [7:0] mem_rdata,
    output logic [3:0] category,
    output logic [2:0] tank_direct,
    output logic       player_tank,
    output logic [9:0] addr,
    output logic       out_valid
);
    import display_pkg::*;

    arb_state_e state_q, state_d;
    logic       issue_wr, issue_err;
    logic [8:0] index;
    logic [9:0] sprite;
    logic       in_range, wr_in_range;

    logic       wr_ack_q, wr_err_q, mem_we_q;
    logic [8:0] mem_addr_q;
    logic [7:0] mem_wdata_q, rd_q;
    logic [3:1]       vld_pipe_q;
    logic [3:1][9:0]  spr_pipe_q;
    logic [3:0] category_q;
    logic [2:0] tank_direct_q;
    logic       player_tank_q, out_valid_q;
    logic [9:0] addr_q;

    tile_index_calc #(.TILE_LOG2(TILE_LOG2)) u_index (
        .pixel_x_i     (pixel_x),
        .pixel_y_i     (pixel_y),
        .index_o       (index),
        .sprite_addr_o (sprite)
    );

    assign in_range    = video_on && (pixel_x < 10'(H_ACTIVE)) && (pixel_y < 10'(V_ACTIVE));
    assign wr_in_range = wr_addr < 9'(MAP_W * MAP_H);

    always_comb begin
        state_d   = state_q;
        issue_wr  = 1'b0;
        issue_err = 1'b0;
        case (state_q)
            RENDER: if (!video_on) state_d = BLANK;
            BLANK, WRITE: begin
                if (video_on) begin
                    state_d = RENDER;
                end else begin
                    state_d = BLANK;
                    if (wr_req && wr_in_range) begin
                        issue_wr = 1'b1;
                        state_d  = WRITE;
                    end else if (wr_req) begin
                        issue_err = 1'b1;
                    end
                end
            end
            default: state_d = RENDER;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= RENDER;
            wr_ack_q      <= 1'b0;
            wr_err_q      <= 1'b0;
            mem_we_q      <= 1'b0;
            mem_addr_q    <= '0;
            mem_wdata_q   <= '0;
            rd_q          <= '0;
            vld_pipe_q    <= '0;
            spr_pipe_q    <= '0;
            category_q    <= NONE;
            tank_direct_q <= '0;
            player_tank_q <= 1'b0;
            addr_q        <= '0;
            out_valid_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            wr_ack_q <= issue_wr | issue_err;
            wr_err_q <= issue_err;
            mem_we_q <= issue_wr;
            // A write edge owns the RAM port, so no pixel is captured then
            if (issue_wr) begin
                mem_addr_q    <= wr_addr;
                mem_wdata_q   <= wr_data;
                vld_pipe_q[1] <= 1'b0;
            end else begin
                mem_addr_q    <= index;
                vld_pipe_q[1] <= in_range;
            end
            spr_pipe_q[1] <= sprite;
            vld_pipe_q[3:2] <= vld_pipe_q[2:1];
            spr_pipe_q[3:2] <= spr_pipe_q[2:1];
            // RAM output for the edge-n address arrives after n+1; register it at n+2
            rd_q <= mem_rdata;
            if (vld_pipe_q[3]) begin
                category_q    <= rd_q[CAT_LSB +: CAT_W];
                tank_direct_q <= rd_q[DIR_LSB +: DIR_W];
                player_tank_q <= rd_q[PLAYER_BIT];
                addr_q        <= spr_pipe_q[3];
                out_valid_q   <= 1'b1;
            end else begin
                category_q    <= NONE;
                tank_direct_q <= '0;
                player_tank_q <= 1'b0;
                addr_q        <= '0;
                out_valid_q   <= 1'b0;
            end
        end
    end

    assign wr_ack      = wr_ack_q;
    assign wr_err      = wr_err_q;
    assign mem_we      = mem_we_q;
    assign mem_addr    = mem_addr_q;
    assign mem_wdata   = mem_wdata_q;
    assign category    = category_q;
    assign tank_direct = tank_direct_q;
    assign player_tank = player_tank_q;
    assign addr        = addr_q;
    assign out_valid   = out_valid_q;
endmodule

// File: tb/tb_map_render_arbiter.sv
// Directed bench for map_render_arbiter with a behavioural sync map RAM.
module tb_map_render_arbiter;
    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       video_on = 1'b0;
    logic [9:0] pixel_x = '0, pixel_y = '0;
    logic       wr_req = 1'b0;
    logic [8:0] wr_addr = '0;
    logic [7:0] wr_data = '0;
    logic       wr_ack, wr_err, mem_we, player_tank, out_valid;
    logic [8:0] mem_addr;
    logic [7:0] mem_wdata;
    logic [7:0] mem_rdata;
    logic [3:0] category;
    logic [2:0] tank_direct;
    logic [9:0] addr;

    int n_chk = 0;
    int n_err = 0;

    map_render_arbiter dut (
        .clk(clk), .rst(rst), .video_on(video_on), .pixel_x(pixel_x), .pixel_y(pixel_y),
        .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data), .wr_ack(wr_ack), .wr_err(wr_err),
        .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .category(category), .tank_direct(tank_direct), .player_tank(player_tank),
        .addr(addr), .out_valid(out_valid)
    );

    always #5 clk = ~clk;

    // Sync RAM: contents reload during reset; read data follows the sampled address by one edge
    logic [7:0] ram [0:511];
    function automatic logic [7:0] ram_init(int i);
        return (i == 43) ? 8'hA2 : 8'(i);
    endfunction
    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 512; i++) ram[i] <= ram_init(i);
            mem_rdata <= '0;
        end else begin
            if (mem_we) ram[mem_addr] <= mem_wdata;
            mem_rdata <= ram[mem_addr];
        end
    end

    typedef struct {
        logic       vo;
        logic [9:0] px;
        logic [9:0] py;
        logic [8:0] idx;
        logic [9:0] spr;
        logic       vld;
        logic [7:0] rd;
    } vec_t;
    vec_t vt [11];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    function automatic logic [18:0] exp_out(input vec_t v);
        if (!v.vld) return '0;
        return {v.rd[3:0], v.rd[6:4], v.rd[7], v.spr, 1'b1};
    endfunction

    logic [18:0] pix_out;
    logic [50:0] all_out;
    assign pix_out = {category, tank_direct, player_tank, addr, out_valid};
    assign all_out = {pix_out, wr_ack, wr_err, mem_we, mem_addr, mem_wdata, 4'h0};

    initial begin
        vt[0]  = '{1'b1, 10'd100,  10'd70,   9'd43,  10'd196,  1'b1, 8'hA2};
        vt[1]  = '{1'b1, 10'd0,    10'd0,    9'd0,   10'd0,    1'b1, 8'h00};
        vt[2]  = '{1'b1, 10'd639,  10'd479,  9'd299, 10'd1023, 1'b1, 8'h2B};
        vt[3]  = '{1'b1, 10'd640,  10'd0,    9'd20,  10'd0,    1'b0, 8'h00};
        vt[4]  = '{1'b1, 10'd0,    10'd480,  9'd300, 10'd0,    1'b0, 8'h00};
        vt[5]  = '{1'b0, 10'd32,   10'd32,   9'd21,  10'd0,    1'b0, 8'h00};
        vt[6]  = '{1'b1, 10'd33,   10'd65,   9'd41,  10'd33,   1'b1, 8'h29};
        vt[7]  = '{1'b1, 10'd1023, 10'd1023, 9'd139, 10'd1023, 1'b0, 8'h00};
        vt[8]  = '{1'b1, 10'd0,    10'd0,    9'd0,   10'd0,    1'b1, 8'h00};
        vt[9]  = '{1'b1, 10'd0,    10'd0,    9'd0,   10'd0,    1'b1, 8'h00};
        vt[10] = '{1'b1, 10'd0,    10'd0,    9'd0,   10'd0,    1'b1, 8'h00};

        // Async reset: outputs clear before any clock edge
        #2 rst = 1'b1;
        #1 chk("reset_state", 32'(all_out != '0), 32'd0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        // Table: one pixel per clock, outputs trail the input by 3 edges
        for (int k = 0; k < 11; k++) begin
            video_on = vt[k].vo; pixel_x = vt[k].px; pixel_y = vt[k].py;
            step();
            chk($sformatf("vec%0d_mem_addr", k), 32'(mem_addr), 32'(vt[k].idx));
            chk($sformatf("vec%0d_mem_we", k), 32'(mem_we), 32'd0);
            if (k >= 3) chk($sformatf("vec%0d_pixel_out", k - 3), 32'(pix_out), 32'(exp_out(vt[k - 3])));
        end

        // Sweep of the last visible line
        video_on = 1'b1; pixel_y = 10'd479;
        for (int i = 0; i < 640; i++) begin
            pixel_x = 10'(i);
            step();
            chk($sformatf("sweep%0d_mem_addr", i), 32'(mem_addr), 32'(280 + i / 32));
            if (i >= 3) chk($sformatf("sweep%0d_out", i), 32'({out_valid, addr}), 32'({1'b1, 5'd31, 5'(i - 3)}));
        end
        video_on = 1'b0; pixel_x = '0; pixel_y = '0;
        for (int i = 0; i < 3; i++) begin
            step();
            chk($sformatf("sweep_tail%0d", i), 32'({out_valid, addr}), 32'({1'b1, 5'd31, 5'(29 + i)}));
        end
        step();
        chk("sweep_tail_drop", 32'(out_valid), 32'd0);

        // Write request during active video waits for blanking
        video_on = 1'b1; pixel_x = 10'd100; pixel_y = 10'd70;
        wr_req = 1'b1; wr_addr = 9'd43; wr_data = 8'h01;
        for (int i = 0; i < 5; i++) begin
            step();
            chk($sformatf("active_hold%0d", i), 32'({wr_ack, mem_we}), 32'd0);
        end
        video_on = 1'b0;
        step();
        chk("blank_enter_no_grant", 32'({wr_ack, mem_we}), 32'd0);
        step();
        chk("blank_grant", 32'({mem_we, wr_ack, wr_err, mem_addr, mem_wdata}), 32'({3'b110, 9'd43, 8'h01}));
        wr_req = 1'b0;
        step();
        chk("grant_single_pulse", 32'({wr_ack, mem_we}), 32'd0);

        // Back-to-back writes
        for (int a = 5; a < 8; a++) begin
            wr_req = 1'b1; wr_addr = 9'(a); wr_data = 8'(8'h10 + a);
            step();
            chk($sformatf("b2b_write%0d", a), 32'({mem_we, wr_ack, mem_addr, mem_wdata}), 32'({2'b11, 9'(a), 8'(8'h10 + a)}));
        end
        wr_req = 1'b0;
        step();
        chk("b2b_end", 32'({wr_ack, mem_we}), 32'd0);

        // Out-of-range address
        wr_req = 1'b1; wr_addr = 9'd300; wr_data = 8'hFF;
        step();
        chk("oor_ack_err", 32'({wr_ack, wr_err, mem_we}), 32'b110);
        wr_req = 1'b0;
        step();
        chk("oor_single_pulse", 32'({wr_ack, wr_err, mem_we}), 32'd0);

        // Video returns right after a write: write completes, read resumes
        wr_req = 1'b1; wr_addr = 9'd9; wr_data = 8'h33;
        step();
        chk("late_write", 32'({mem_we, mem_addr}), 32'({1'b1, 9'd9}));
        wr_req = 1'b0; video_on = 1'b1; pixel_x = 10'd100; pixel_y = 10'd70;
        step();
        chk("read_resume", 32'({mem_we, wr_ack, mem_addr}), 32'({2'b00, 9'd43}));
        repeat (3) step();
        chk("readback_written", 32'(pix_out), 32'({4'd1, 3'd0, 1'b0, 10'd196, 1'b1}));

        // Reset mid-pipeline together with a new request
        wr_req = 1'b1; wr_addr = 9'd50; wr_data = 8'h77;
        #2 rst = 1'b1; video_on = 1'b0;
        #1 chk("midrun_reset_async", 32'(all_out != '0), 32'd0);
        step();
        chk("reset_no_ack", 32'({wr_ack, mem_we, out_valid}), 32'd0);
        rst = 1'b0;
        step();
        chk("post_reset_render_to_blank", 32'({wr_ack, mem_we}), 32'd0);
        step();
        chk("post_reset_grant", 32'({mem_we, wr_ack, mem_addr, mem_wdata}), 32'({2'b11, 9'd50, 8'h77}));
        wr_req = 1'b0;
        step();
        chk("post_reset_done", 32'({wr_ack, mem_we}), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule
